// File: rtl/fetch_port.sv
// -----------------------------------------------------------------------------
// fetch_port
//   Bus-side responder for the fetch stage's instruction interface. A two-entry
//   instruction buffer answers fetch_address combinationally. On a miss a
//   demand read runs on the instruction memory bus while fetch_ready stays low
//   so the hazard unit stalls fetch. After a hit the next sequential word is
//   prefetched into the other entry (when PREFETCH=1).
//
// Parameters
//   PREFETCH      1: sequential prefetch after hits, 0: demand reads only
//
// Ports
//   clk           clock
//   reset         asynchronous, active-high reset
//   fetch_address word address requested by fetch (bits [1:0] ignored)
//   fetch_data    instruction for fetch_address, 0 when not ready
//   fetch_ready   combinational hit: fetch_data/fetch_error valid this cycle
//   fetch_error   hit entry was filled with a bus error, 0 when not ready
//   flush         invalidate both entries (fence.i)
//   mem_req       registered read request, held until mem_ack
//   mem_addr      registered read word address, bits [1:0]=0
//   mem_ack       read completes on an edge where mem_req && mem_ack
//   mem_rdata     read data, valid with mem_ack
//   mem_err       bus error, valid with mem_ack
// -----------------------------------------------------------------------------
module fetch_port #(
  parameter bit PREFETCH = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] fetch_address,
  output logic [31:0] fetch_data,
  output logic        fetch_ready,
  output logic        fetch_error,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEMAND,
    ST_PREFETCH
  } state_e;

  // Buffer entries: valid bits are control state, tag/data/err are payload.
  logic [1:0]  valid_q;
  logic [29:0] tag_q  [2];
  logic [31:0] data_q [2];
  logic [1:0]  err_q;

  // Transaction state.
  state_e      state_q;
  logic        mem_req_q;
  logic [29:0] req_tag_q;   // word address of the outstanding (or last) read
  logic        pf_idx_q;    // entry that hit when the prefetch was issued
  logic        discard_q;   // outstanding read was overtaken by a flush

  // Lookup.
  logic [29:0] fetch_tag;
  logic [1:0]  hit;
  logic        any_hit;
  logic        hit_idx;
  logic [29:0] next_tag;
  logic        next_buffered;
  logic        pf_ok;

  // Completion.
  logic        done;
  logic        fill_we;
  logic        fill_idx;

  logic        unused_addr_bits;
  assign unused_addr_bits = ^fetch_address[1:0];

  assign fetch_tag = fetch_address[31:2];
  assign hit[0]    = valid_q[0] && (tag_q[0] == fetch_tag);
  assign hit[1]    = valid_q[1] && (tag_q[1] == fetch_tag);
  assign any_hit   = |hit;
  // The entries never share a tag, so at most one hit bit is set.
  assign hit_idx   = hit[1];

  assign next_tag      = tag_q[hit_idx] + 30'd1;
  assign next_buffered = (valid_q[0] && (tag_q[0] == next_tag)) ||
                         (valid_q[1] && (tag_q[1] == next_tag));
  // No prefetch past an errored word, past the top of memory, or of a word
  // already held in the buffer.
  assign pf_ok = PREFETCH && !err_q[hit_idx] && (tag_q[hit_idx] != '1) &&
                 !next_buffered;

  assign done     = mem_req_q && mem_ack;
  // A flush on the completion edge, or one seen earlier, drops the fill.
  assign fill_we  = done && !flush && !discard_q;
  assign fill_idx = (state_q == ST_PREFETCH) ? ~pf_idx_q : 1'b0;

  // Fetch-side outputs are combinational so a hit costs no cycles.
  // NOTE: every always_comb output gets a default first, otherwise a path
  // that skips the assignment would infer a latch.
  always_comb begin
    fetch_ready = 1'b0;
    fetch_data  = 32'h0;
    fetch_error = 1'b0;
    if (any_hit && !flush) begin
      fetch_ready = 1'b1;
      fetch_data  = data_q[hit_idx];
      fetch_error = err_q[hit_idx];
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = {req_tag_q, 2'b00};

  // Control FSM with registered bus outputs.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side reads the pre-edge value regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      valid_q   <= 2'b00;
      mem_req_q <= 1'b0;
      req_tag_q <= 30'h0;
      pf_idx_q  <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      if (fill_we) begin
        valid_q[fill_idx] <= 1'b1;
      end
      if (flush) begin
        valid_q <= 2'b00;
      end

      case (state_q)
        ST_IDLE: begin
          // Entries are being invalidated during a flush cycle; wait for the
          // next cycle to re-evaluate the address.
          if (!flush) begin
            if (!any_hit) begin
              mem_req_q <= 1'b1;
              req_tag_q <= fetch_tag;
              state_q   <= ST_DEMAND;
            end else if (pf_ok) begin
              mem_req_q <= 1'b1;
              req_tag_q <= next_tag;
              pf_idx_q  <= hit_idx;
              state_q   <= ST_PREFETCH;
            end
          end
        end
        ST_DEMAND, ST_PREFETCH: begin
          if (done) begin
            mem_req_q <= 1'b0;
            discard_q <= 1'b0;
            state_q   <= ST_IDLE;
          end else if (flush) begin
            discard_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Entry payload: only the valid bits need a reset value.
  // NOTE: storage arrays are deliberately left out of reset; valid bits gate
  // every use of them, and an unreset array maps onto plain flops or RAM.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[fill_idx]  <= req_tag_q;
      data_q[fill_idx] <= mem_rdata;
      err_q[fill_idx]  <= mem_err;
    end
  end

endmodule

// File: tb/tb_fetch_port.sv
// -----------------------------------------------------------------------------
// tb_fetch_port
//   Directed bench for fetch_port. Inputs change 1 ns after the rising edge,
//   outputs are compared a further 1 ns later, well away from the next edge.
//   Cycle n is the interval after edge n; cycle 0 is the first cycle after
//   reset is released.
// -----------------------------------------------------------------------------
module tb_fetch_port;

  logic        clk;
  logic        reset;
  logic [31:0] fetch_address;
  logic [31:0] fetch_data;
  logic        fetch_ready;
  logic        fetch_error;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_err;

  int n_checks = 0;
  int n_errors = 0;

  fetch_port #(.PREFETCH(1'b1)) dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_address (fetch_address),
    .fetch_data    (fetch_data),
    .fetch_ready   (fetch_ready),
    .fetch_error   (fetch_error),
    .flush         (flush),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .mem_err       (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic ack(input logic [31:0] data, input logic err);
    mem_ack   = 1'b1;
    mem_rdata = data;
    mem_err   = err;
  endtask

  task automatic no_ack();
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    mem_err   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    fetch_address = 32'h100;
    flush         = 1'b0;
    no_ack();

    // Reset state.
    repeat (2) @(posedge clk);
    #2;
    check("rst_mem_req",  mem_req,     0);
    check("rst_mem_addr", mem_addr,    0);
    check("rst_ready",    fetch_ready, 0);
    check("rst_data",     fetch_data,  0);
    check("rst_error",    fetch_error, 0);

    // Cold miss of 0x100.
    next_cycle();                        // cycle 0
    reset = 1'b0;
    settle();
    check("cold_c0_ready", fetch_ready, 0);
    next_cycle();                        // cycle 1
    ack(32'h0000_0013, 1'b0);
    settle();
    check("cold_c1_req",  mem_req,  1);
    check("cold_c1_addr", mem_addr, 32'h100);
    check("cold_c1_ready", fetch_ready, 0);
    next_cycle();                        // cycle 2
    no_ack();
    settle();
    check("cold_c2_ready", fetch_ready, 1);
    check("cold_c2_data",  fetch_data,  32'h13);
    check("cold_c2_req",   mem_req,     0);

    // Sequential prefetch of 0x104 into E1.
    next_cycle();                        // cycle 3
    ack(32'h0010_0093, 1'b0);
    settle();
    check("pf_c3_req",   mem_req,     1);
    check("pf_c3_addr",  mem_addr,    32'h104);
    check("pf_c3_ready", fetch_ready, 1);
    next_cycle();                        // cycle 4
    no_ack();
    fetch_address = 32'h104;
    settle();
    check("pf_c4_req",   mem_req,     0);
    check("pf_c4_ready", fetch_ready, 1);
    check("pf_c4_data",  fetch_data,  32'h0010_0093);
    next_cycle();                        // cycle 5: prefetch 0x108 into E0
    ack(32'h0020_0113, 1'b0);
    settle();
    check("pf_c5_addr", mem_addr, 32'h108);
    next_cycle();                        // cycle 6
    no_ack();
    fetch_address = 32'h108;
    settle();
    check("pf_c6_data", fetch_data, 32'h0020_0113);
    fetch_address = 32'h104;
    settle();
    check("pf_c6_e1_data", fetch_data, 32'h0010_0093);
    fetch_address = 32'h108;
    next_cycle();                        // cycle 7: prefetch 0x10C into E1
    ack(32'h0030_0193, 1'b0);
    fetch_address = 32'h200;
    settle();
    check("pf_c7_addr", mem_addr, 32'h10C);

    // Branch mid-demand: miss 0x200, switch to 0x400 in wait cycle 1.
    next_cycle();                        // cycle 8
    no_ack();
    settle();
    check("br_c8_ready", fetch_ready, 0);
    check("br_c8_req",   mem_req,     0);
    next_cycle();                        // cycle 9: wait 1
    fetch_address = 32'h400;
    settle();
    check("br_c9_addr",  mem_addr,    32'h200);
    check("br_c9_ready", fetch_ready, 0);
    next_cycle();                        // cycle 10: wait 2
    settle();
    check("br_c10_req",   mem_req,     1);
    check("br_c10_ready", fetch_ready, 0);
    next_cycle();                        // cycle 11: wait 3
    settle();
    check("br_c11_addr", mem_addr, 32'h200);
    next_cycle();                        // cycle 12: ack
    ack(32'hAAAA_0001, 1'b0);
    settle();
    check("br_c12_ready", fetch_ready, 0);
    next_cycle();                        // cycle 13
    no_ack();
    fetch_address = 32'h200;
    settle();
    check("br_c13_fill_ready", fetch_ready, 1);
    check("br_c13_fill_data",  fetch_data,  32'hAAAA_0001);
    fetch_address = 32'h400;
    settle();
    check("br_c13_ready", fetch_ready, 0);
    check("br_c13_req",   mem_req,     0);
    next_cycle();                        // cycle 14
    ack(32'hBBBB_0002, 1'b0);
    settle();
    check("br_c14_req",   mem_req,     1);
    check("br_c14_addr",  mem_addr,    32'h400);
    check("br_c14_ready", fetch_ready, 0);
    next_cycle();                        // cycle 15
    no_ack();
    settle();
    check("br_c15_ready", fetch_ready, 1);
    check("br_c15_data",  fetch_data,  32'hBBBB_0002);

    // Flush on the ack edge of a demand for 0x300.
    next_cycle();                        // cycle 16: prefetch 0x404
    ack(32'hCCCC_0003, 1'b0);
    settle();
    check("fl_c16_addr", mem_addr, 32'h404);
    next_cycle();                        // cycle 17
    no_ack();
    fetch_address = 32'h300;
    settle();
    check("fl_c17_ready", fetch_ready, 0);
    next_cycle();                        // cycle 18
    ack(32'hDDDD_0004, 1'b0);
    flush = 1'b1;
    fetch_address = 32'h400;
    settle();
    check("fl_c18_ready_during_flush", fetch_ready, 0);
    check("fl_c18_addr", mem_addr, 32'h300);
    fetch_address = 32'h300;
    next_cycle();                        // cycle 19
    no_ack();
    flush = 1'b0;
    settle();
    check("fl_c19_ready", fetch_ready, 0);
    check("fl_c19_req",   mem_req,     0);
    fetch_address = 32'h400;
    settle();
    check("fl_c19_e0_gone", fetch_ready, 0);
    fetch_address = 32'h404;
    settle();
    check("fl_c19_e1_gone", fetch_ready, 0);
    fetch_address = 32'h300;
    next_cycle();                        // cycle 20: re-read 0x300
    ack(32'h0EEE_0005, 1'b0);
    settle();
    check("fl_c20_req",  mem_req,  1);
    check("fl_c20_addr", mem_addr, 32'h300);
    next_cycle();                        // cycle 21
    no_ack();
    settle();
    check("fl_c21_ready", fetch_ready, 1);
    check("fl_c21_data",  fetch_data,  32'h0EEE_0005);
    fetch_address = 32'h500;

    // Bus error on 0x500, then wrap-around at 0xFFFFFFFC.
    next_cycle();                        // cycle 22
    ack(32'hDEAD_0006, 1'b1);
    settle();
    check("err_c22_addr", mem_addr, 32'h500);
    next_cycle();                        // cycle 23
    no_ack();
    settle();
    check("err_c23_ready", fetch_ready, 1);
    check("err_c23_error", fetch_error, 1);
    check("err_c23_data",  fetch_data,  32'hDEAD_0006);
    next_cycle();                        // cycle 24
    settle();
    check("err_c24_no_pf", mem_req, 0);
    fetch_address = 32'hFFFF_FFFC;
    next_cycle();                        // cycle 25
    ack(32'h1111_0007, 1'b0);
    settle();
    check("wrap_c25_addr", mem_addr, 32'hFFFF_FFFC);
    next_cycle();                        // cycle 26
    no_ack();
    settle();
    check("wrap_c26_ready", fetch_ready, 1);
    check("wrap_c26_error", fetch_error, 0);
    check("wrap_c26_data",  fetch_data,  32'h1111_0007);
    next_cycle();                        // cycle 27
    settle();
    check("wrap_c27_no_pf", mem_req, 0);
    fetch_address = 32'h600;

    // Flush while a demand is outstanding: the later fill is discarded.
    next_cycle();                        // cycle 28
    flush = 1'b1;
    fetch_address = 32'hFFFF_FFFC;
    settle();
    check("dis_c28_ready_during_flush", fetch_ready, 0);
    check("dis_c28_addr", mem_addr, 32'h600);
    fetch_address = 32'h600;
    next_cycle();                        // cycle 29
    flush = 1'b0;
    ack(32'h2222_0008, 1'b0);
    settle();
    check("dis_c29_req", mem_req, 1);
    next_cycle();                        // cycle 30
    no_ack();
    settle();
    check("dis_c30_ready", fetch_ready, 0);
    check("dis_c30_req",   mem_req,     0);
    next_cycle();                        // cycle 31: re-read 0x600
    settle();
    check("dis_c31_req",  mem_req,  1);
    check("dis_c31_addr", mem_addr, 32'h600);

    // Reset mid-transaction takes effect without a clock edge.
    #1;
    reset = 1'b1;
    #1;
    check("rstmid_req",   mem_req,     0);
    check("rstmid_addr",  mem_addr,    0);
    check("rstmid_ready", fetch_ready, 0);
    check("rstmid_data",  fetch_data,  0);
    next_cycle();
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_port.md
# fetch_port

Bus-side responder for the fetch stage's instruction interface. Every cycle it answers the word at `fetch_address` from a two-entry instruction buffer. On a miss it runs a read on the instruction memory bus and holds `fetch_ready` low, which the hazard unit uses to stall fetch. After each hit it prefetches the next sequential word. Sits in busio, between the fetch stage and the external instruction memory.

## Interface
- `PREFETCH`, default 1: 1 enables sequential prefetch; 0 issues demand reads only.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `fetch_address` in 32: word address requested by fetch; bits [1:0] ignored.
- `fetch_data` out 32: instruction for `fetch_address`; 0 when `fetch_ready`=0.
- `fetch_ready` out 1: combinational hit; `fetch_data` and `fetch_error` are valid this cycle.
- `fetch_error` out 1: the hit entry was filled with a bus error; 0 when not ready.
- `flush` in 1: invalidate both entries (fence.i).
- `mem_req` out 1: read request, registered.
- `mem_addr` out 32: read word address, registered, bits [1:0]=0.
- `mem_ack` in 1: read completes on an edge where `mem_req`&&`mem_ack`.
- `mem_rdata` in 32: read data, valid with `mem_ack`.
- `mem_err` in 1: bus error, valid with `mem_ack`.

## Operation
- Each entry E0/E1 holds {valid, tag[31:2], data[31:0], err}. An entry hits when it is valid and tag == `fetch_address`[31:2].
  - E0 and E1 never hold the same tag.
- Outputs on a hit: `fetch_ready`=1, `fetch_data`=entry data, `fetch_error`=entry err.
- State machine states: IDLE, DEMAND, PREFETCH.
- IDLE, miss: set `mem_req`=1 and `mem_addr`={`fetch_address`[31:2],2'b0}, go to DEMAND.
- IDLE, hit in Ek (PREFETCH=1): go to PREFETCH with `mem_addr`=tag+1 (word) only if all of these hold:
  - the hit entry has err=0;
  - tag != 30'h3FFFFFFF (no wrap-around prefetch);
  - tag+1 is not already buffered.
  - Otherwise stay in IDLE with `mem_req`=0.
- DEMAND completion: write E0 with {1, req tag, `mem_rdata`, `mem_err`}, drop `mem_req`, return to IDLE.
- PREFETCH completion: write E(1-k) with the same fields, where k is the entry index latched when the prefetch was issued. Drop `mem_req` and return to IDLE.
- `mem_addr` stays stable while `mem_req`=1. A request is never withdrawn before ack.
- Address change mid-transaction (branch/trap/mret):
  - The transaction still completes and its fill is written normally.
  - IDLE then re-evaluates the new `fetch_address`.
  - No new request is issued until the outstanding one is acked.
- `flush`:
  - On the edge it is sampled, both valid bits clear.
  - If a transaction is outstanding, or completes on that same edge, set `discard`. The data of that transaction is dropped, not written.
  - `discard` clears when the transaction completes.
  - `fetch_ready`=0 during any cycle in which `flush`=1.
- Simultaneous `flush` and `mem_ack`: the flush wins and nothing is written.
- Errors are stored, not raised at fill. The error is visible only through `fetch_error` when the errored word is hit. No prefetch is issued past an errored word.
- Reset values:
  - E0.valid=E1.valid=0, state IDLE, `discard`=0.
  - `mem_req`=0, `mem_addr`=0.
  - `fetch_ready`=0, `fetch_data`=0, `fetch_error`=0.
  - Reset asserted mid-transaction abandons it. The memory must tolerate a dropped request.

## Timing
- Hit: zero latency, `fetch_ready` is combinational in the same cycle.
- Miss detected in cycle 0:
  - `mem_req` is high from edge 1.
  - With `mem_ack` in cycle 1, the fill happens at edge 2 and `fetch_ready`=1 in cycle 2.
  - Minimum miss penalty is 2 cycles, plus 1 per memory wait cycle.
- Prefetch: issued at the edge after the first hit cycle. With 1-cycle memory, a sequential stream sustains 1 instruction per 2 cycles.
- Only one outstanding transaction at a time. A new request may start at the earliest the cycle after completion, since the state passes through IDLE.

## Test plan
- Cold miss:
  - Stimulus: reset, then `fetch_address`=0x100, memory acks in the first request cycle with 0x00000013.
  - Required: `mem_req` high cycles 1–1 with `mem_addr`=0x100; cycle 2 `fetch_ready`=1, `fetch_data`=0x13.
- Sequential prefetch:
  - Stimulus: hit 0x100, then hold 0x100.
  - Required: `mem_req` with `mem_addr`=0x104; after ack, `fetch_address`=0x104 hits in E1 with `fetch_ready`=1 in the same cycle.
- Branch mid-demand:
  - Stimulus: miss 0x200 with 3 wait cycles; switch `fetch_address` to 0x400 in wait cycle 1.
  - Required: 0x200 fill written; next `mem_req` has `mem_addr`=0x400; `fetch_ready` stays 0 until the 0x400 fill.
- Flush on the ack edge:
  - Stimulus: assert `flush` in the cycle `mem_ack`=1 for 0x300.
  - Required: no entry valid; the later access to 0x300 misses and re-reads.
- Bus error:
  - Stimulus: demand 0x500 acked with `mem_err`=1.
  - Required: `fetch_ready`=1, `fetch_error`=1, no prefetch of 0x504; then 0xFFFFFFFC hit issues no prefetch (wrap-around).
- Reset mid-transaction:
  - Stimulus: assert `reset` while `mem_req`=1.
  - Required: `mem_req`=0, `mem_addr`=0, `fetch_ready`=0 immediately, without waiting for a clock edge.
